// File: rtl/seg7_readback_decoder.sv
// ============================================================================
// Module  : seg7_readback_decoder
// Brief   : Monitors active-low 7-segment drive lines. It synchronises them,
//           debounces them, decodes each accepted pattern to a digit and checks
//           that successive digits form a +1 counting sequence.
//           Optional macro SEG7_HEX_EN: A-F decode as digits, sequence mod 16.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_readback_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       seg_in,
    output logic [3:0]       digit,
    output logic             digit_valid,
    output logic             invalid,
    output logic             seq_err,
    output logic             locked,
    output logic [CNT_W-1:0] err_count
);

    localparam int HW = $clog2(STABLE_CYCLES + 1);
    localparam logic [HW-1:0] C_STABLE = HW'(STABLE_CYCLES);
    localparam logic [6:0]    C_BLANK  = 7'h7F;
`ifdef SEG7_HEX_EN
    localparam logic [3:0]    C_LAST   = 4'd15;
`else
    localparam logic [3:0]    C_LAST   = 4'd9;
`endif

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t           r_state;
    logic [6:0]       r_sync1;
    logic [6:0]       r_seg_s;
    logic [6:0]       r_prev;
    logic [6:0]       r_acc_pat;
    logic [HW-1:0]    r_held;
    logic [3:0]       r_digit;
    logic             r_digit_valid;
    logic             r_invalid;
    logic             r_seq_err;
    logic [CNT_W-1:0] r_err_count;

    logic [HW-1:0]    w_held;
    logic             w_accept;
    logic             w_is_digit;
    logic             w_is_blank;
    logic [3:0]       w_dval;
    logic [3:0]       w_expect;
    logic             w_inv_evt;
    logic             w_seq_evt;

    // w_held is the number of clocks seg_s has shown its current value,
    // counting the present one, saturating at STABLE_CYCLES.
    always_comb begin
        w_held = HW'(1);
        if (r_seg_s == r_prev) begin
            if (r_held >= C_STABLE) begin
                w_held = C_STABLE;
            end else begin
                w_held = r_held + 1'b1;
            end
        end
        w_accept = (w_held == C_STABLE) && (r_seg_s != r_acc_pat);
    end

    // Patterns are gfedcba, active-low.
    always_comb begin
        w_is_digit = 1'b1;
        w_dval     = 4'd0;
        case (r_seg_s)
            7'b1000000: w_dval = 4'd0;
            7'b1111001: w_dval = 4'd1;
            7'b0100100: w_dval = 4'd2;
            7'b0110000: w_dval = 4'd3;
            7'b0011001: w_dval = 4'd4;
            7'b0010010: w_dval = 4'd5;
            7'b0000010: w_dval = 4'd6;
            7'b1111000: w_dval = 4'd7;
            7'b0000000: w_dval = 4'd8;
            7'b0010000: w_dval = 4'd9;
`ifdef SEG7_HEX_EN
            7'b0001000: w_dval = 4'd10;
            7'b0000011: w_dval = 4'd11;
            7'b1000110: w_dval = 4'd12;
            7'b0100001: w_dval = 4'd13;
            7'b0000110: w_dval = 4'd14;
            7'b0001110: w_dval = 4'd15;
`endif
            default:    w_is_digit = 1'b0;
        endcase
        w_is_blank = (r_seg_s == C_BLANK);
    end

    always_comb begin
        w_expect  = (r_digit == C_LAST) ? 4'd0 : (r_digit + 4'd1);
        w_inv_evt = w_accept && !w_is_digit && !w_is_blank;
        w_seq_evt = w_accept && w_is_digit && (r_state == LOCK) && (w_dval != w_expect);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1       <= C_BLANK;
            r_seg_s       <= C_BLANK;
            r_prev        <= C_BLANK;
            r_acc_pat     <= C_BLANK;
            r_held        <= '0;
            r_state       <= IDLE;
            r_digit       <= 4'd0;
            r_digit_valid <= 1'b0;
            r_invalid     <= 1'b0;
            r_seq_err     <= 1'b0;
            r_err_count   <= '0;
        end else begin
            r_sync1       <= seg_in;
            r_seg_s       <= r_sync1;
            r_prev        <= r_seg_s;
            r_held        <= w_held;
            r_digit_valid <= 1'b0;
            r_invalid     <= 1'b0;
            r_seq_err     <= 1'b0;

            if (w_accept) begin
                r_acc_pat <= r_seg_s;
                if (w_is_digit) begin
                    r_digit_valid <= 1'b1;
                    r_digit       <= w_dval;
                    r_state       <= LOCK;
                end else if (w_is_blank) begin
                    r_state       <= IDLE;
                end else begin
                    r_invalid     <= 1'b1;
                    r_state       <= IDLE;
                end
            end

            r_seq_err <= w_seq_evt;
            // Invalid and sequence events never coincide, so one step suffices.
            if ((w_inv_evt || w_seq_evt) && !(&r_err_count)) begin
                r_err_count <= r_err_count + 1'b1;
            end
        end
    end

    assign digit       = r_digit;
    assign digit_valid = r_digit_valid;
    assign invalid     = r_invalid;
    assign seq_err     = r_seq_err;
    assign locked      = (r_state == LOCK);
    assign err_count   = r_err_count;

endmodule

`default_nettype wire
